// File: rtl/soc_system_vga_fill_ctrl.sv
// rtl/soc_system_vga_fill_ctrl.sv - rectangle-fill engine and pixel write-port arbiter
// Walks a clipped rectangle in raster order, one pixel per cycle; PIO writes preempt it.
module soc_system_vga_fill_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [ADDR_W-1:0] pio_addr,
  input  logic [PIX_W-1:0]  pio_data,
  input  logic              pio_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_we,
  output logic              irq
);

  localparam logic [10:0]       L_HRES   = 11'(H_RES);
  localparam logic [9:0]        L_VRES   = 10'(V_RES);
  localparam logic [ADDR_W-1:0] L_HRES_A = ADDR_W'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Host-visible registers
  logic [9:0]        r_x0;
  logic [8:0]        r_y0;
  logic [10:0]       r_w;
  logic [9:0]        r_h;
  logic [PIX_W-1:0]  r_color;
  logic              r_irq_en;
  logic              r_done;

  // Engine working copies, captured in SETUP
  logic [10:0]       r_cw;
  logic [9:0]        r_ch;
  logic [9:0]        r_cx0;
  logic [PIX_W-1:0]  r_lcolor;
  logic [ADDR_W-1:0] r_row_base;
  logic [10:0]       r_col;
  logic [9:0]        r_row;

  logic [ADDR_W-1:0] r_pix_addr;
  logic [PIX_W-1:0]  r_pix_data;
  logic              r_pix_we;

  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_start;
  logic              w_abort;
  logic              w_busy;
  logic [10:0]       w_x_room;
  logic [9:0]        w_y_room;
  logic [10:0]       w_clip_w;
  logic [9:0]        w_clip_h;
  logic [ADDR_W-1:0] w_row_base;
  logic [ADDR_W-1:0] w_eng_addr;
  logic              w_last_col;
  logic              w_last_row;

  assign w_wr      = chipselect & ~write_n;
  assign w_ctrl_wr = w_wr & (address == 2'd0);
  assign w_abort   = w_ctrl_wr & writedata[1];
  assign w_start   = w_ctrl_wr & writedata[0] & ~writedata[1];
  assign w_busy    = (r_state != S_IDLE);

  // Clipping: an origin outside the screen yields an empty rectangle
  assign w_x_room = L_HRES - {1'b0, r_x0};
  assign w_y_room = L_VRES - {1'b0, r_y0};
  assign w_clip_w = ({1'b0, r_x0} >= L_HRES) ? 11'd0 :
                    ((r_w < w_x_room) ? r_w : w_x_room);
  assign w_clip_h = ({1'b0, r_y0} >= L_VRES) ? 10'd0 :
                    ((r_h < w_y_room) ? r_h : w_y_room);

  // y0*H_RES as a sum of shifted copies of y0, one per set bit of H_RES
  always_comb begin
    w_row_base = '0;
    for (int i = 0; i < 32; i++) begin
      if (H_RES[i]) begin
        w_row_base = w_row_base + (ADDR_W'(r_y0) << i);
      end
    end
  end

  assign w_eng_addr = r_row_base + ADDR_W'(r_cx0) + ADDR_W'(r_col);
  assign w_last_col = (r_col == r_cw - 11'd1);
  assign w_last_row = (r_row == r_ch - 10'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_SETUP;
      S_SETUP: w_next = ((w_clip_w == 11'd0) || (w_clip_h == 10'd0)) ? S_DONE : S_RUN;
      S_RUN:   if (!pio_we && w_last_col && w_last_row) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_color  <= '0;
      r_irq_en <= 1'b0;
    end else if (w_wr) begin
      case (address)
        2'd0: r_irq_en <= writedata[2];
        2'd1: begin
          r_x0 <= writedata[9:0];
          r_y0 <= writedata[24:16];
        end
        2'd2: begin
          r_w <= writedata[10:0];
          r_h <= writedata[25:16];
        end
        default: r_color <= writedata[PIX_W-1:0];
      endcase
    end
  end

  // Completion sets done even if the host clears it in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else if ((r_state == S_DONE) && !w_abort) begin
      r_done <= 1'b1;
    end else if (w_ctrl_wr && writedata[3]) begin
      r_done <= 1'b0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cw       <= '0;
      r_ch       <= '0;
      r_cx0      <= '0;
      r_lcolor   <= '0;
      r_row_base <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else if (r_state == S_SETUP) begin
      r_cw       <= w_clip_w;
      r_ch       <= w_clip_h;
      r_cx0      <= r_x0;
      r_lcolor   <= r_color;
      r_row_base <= w_row_base;
      r_col      <= '0;
      r_row      <= '0;
    end else if ((r_state == S_RUN) && !pio_we) begin
      if (w_last_col) begin
        r_col      <= '0;
        r_row      <= r_row + 10'd1;
        r_row_base <= r_row_base + L_HRES_A;
      end else begin
        r_col <= r_col + 11'd1;
      end
    end
  end

  // Registered write port; PIO wins, and a RUN-cycle write issued during abort still lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_we   <= 1'b0;
      r_pix_addr <= '0;
      r_pix_data <= '0;
    end else if (pio_we) begin
      r_pix_we   <= 1'b1;
      r_pix_addr <= pio_addr;
      r_pix_data <= pio_data;
    end else if (r_state == S_RUN) begin
      r_pix_we   <= 1'b1;
      r_pix_addr <= w_eng_addr;
      r_pix_data <= r_lcolor;
    end else begin
      r_pix_we <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {29'd0, r_irq_en, r_done, w_busy};
      2'd1:    readdata = {7'd0, r_y0, 6'd0, r_x0};
      2'd2:    readdata = {6'd0, r_h, 5'd0, r_w};
      default: readdata = {{(32-PIX_W){1'b0}}, r_color};
    endcase
  end

  assign pix_we   = r_pix_we;
  assign pix_addr = r_pix_addr;
  assign pix_data = r_pix_data;
  assign irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_soc_system_vga_fill_ctrl.sv
// tb/tb_soc_system_vga_fill_ctrl.sv - bench for the VGA rectangle-fill controller
// Expected pixel streams come from a raster-loop model of the clipped rectangle.
module tb_soc_system_vga_fill_ctrl;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [ADDR_W-1:0] pio_addr;
  logic [PIX_W-1:0]  pio_data;
  logic              pio_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_we;
  logic              irq;

  int total = 0;
  int bad   = 0;

  logic                    pio_prev = 1'b0;
  logic [ADDR_W-1:0]       eng_addr_q[$];
  logic [PIX_W-1:0]        eng_data_q[$];
  logic [ADDR_W+PIX_W-1:0] pio_obs_q[$];
  logic [ADDR_W+PIX_W-1:0] pio_exp_q[$];
  int                      exp_addr_q[$];
  bit                      rand_pio = 1'b0;

  always #5 clk = ~clk;

  soc_system_vga_fill_ctrl #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .pio_addr(pio_addr), .pio_data(pio_data), .pio_we(pio_we),
    .pix_addr(pix_addr), .pix_data(pix_data), .pix_we(pix_we), .irq(irq)
  );

  // A write visible now came from PIO iff pio_we was high at the previous edge
  always @(posedge clk) pio_prev <= pio_we;

  always @(negedge clk) begin
    if (reset_n && pix_we) begin
      if (pio_prev) begin
        pio_obs_q.push_back({pix_addr, pix_data});
      end else begin
        eng_addr_q.push_back(pix_addr);
        eng_data_q.push_back(pix_data);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_pio && ($urandom_range(0, 3) == 0)) begin
      pio_we   = 1'b1;
      pio_addr = ADDR_W'($urandom);
      pio_data = PIX_W'($urandom);
      pio_exp_q.push_back({pio_addr, pio_data});
    end else begin
      pio_we = 1'b0;
    end
  endtask

  task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    #1;
  endtask

  task automatic program_rect(input int x0, input int y0, input int w, input int h,
                              input logic [7:0] color);
    avm_write(2'd1, {7'd0, 9'(y0), 6'd0, 10'(x0)});
    avm_write(2'd2, {6'd0, 10'(h), 5'd0, 11'(w)});
    avm_write(2'd3, {24'd0, color});
  endtask

  task automatic clear_queues();
    eng_addr_q.delete();
    eng_data_q.delete();
    pio_obs_q.delete();
    pio_exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((readdata[0] !== 1'b0) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, 32'(readdata[0]), 32'd0);
    rand_pio = 1'b0;
    tick();
    tick();
  endtask

  // Reference: every pixel of the clipped rectangle, row by row
  task automatic build_exp(input int x0, input int y0, input int w, input int h);
    int cw;
    int ch;
    exp_addr_q.delete();
    cw = (x0 >= H_RES) ? 0 : ((w < H_RES - x0) ? w : H_RES - x0);
    ch = (y0 >= V_RES) ? 0 : ((h < V_RES - y0) ? h : V_RES - y0);
    for (int r = 0; r < ch; r++)
      for (int c = 0; c < cw; c++)
        exp_addr_q.push_back((y0 + r) * H_RES + x0 + c);
  endtask

  task automatic compare_fill(input string tag, input int x0, input int y0, input int w,
                              input int h, input logic [7:0] color);
    int bad_i = -1;
    int n;
    build_exp(x0, y0, w, h);
    check({tag, "_count"}, 32'(eng_addr_q.size()), 32'(exp_addr_q.size()));
    n = (eng_addr_q.size() < exp_addr_q.size()) ? eng_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++)
      if ((bad_i < 0) && ((int'(eng_addr_q[i]) != exp_addr_q[i]) || (eng_data_q[i] !== color)))
        bad_i = i;
    check({tag, "_first_bad_idx"}, 32'(bad_i), 32'hFFFF_FFFF);
    check({tag, "_pio_count"}, 32'(pio_obs_q.size()), 32'(pio_exp_q.size()));
    bad_i = -1;
    n = (pio_obs_q.size() < pio_exp_q.size()) ? pio_obs_q.size() : pio_exp_q.size();
    for (int i = 0; i < n; i++)
      if ((bad_i < 0) && (pio_obs_q[i] !== pio_exp_q[i])) bad_i = i;
    check({tag, "_pio_first_bad_idx"}, 32'(bad_i), 32'hFFFF_FFFF);
  endtask

  initial begin
    int n1;
    int bad_i;
    int x0;
    int y0;
    int w;
    int h;
    logic [7:0] col;

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    pio_addr   = '0;
    pio_data   = '0;
    pio_we     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_we", 32'(pix_we), 32'd0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ctrl", readdata, 32'd0);
    reset_n = 1'b1;
    tick();

    // T1: basic fill with latency probe
    clear_queues();
    program_rect(10, 5, 3, 2, 8'hA5);
    avm_write(2'd0, 32'h1);
    check("t1_busy_setup", readdata, 32'h1);
    tick();
    check("t1_no_write_n2", 32'(pix_we), 32'd0);
    tick();
    check("t1_first_we_n3", 32'(pix_we), 32'd1);
    check("t1_first_addr_n3", 32'(pix_addr), 32'd3210);
    wait_idle("t1_idle", 50);
    compare_fill("t1", 10, 5, 3, 2, 8'hA5);
    check("t1_ctrl_done", readdata, 32'h2);

    // T2: two PIO cycles mid-RUN stall the engine without losing pixels
    clear_queues();
    avm_write(2'd0, 32'h1);
    n1 = 0;
    while ((eng_addr_q.size() < 2) && (n1 < 20)) begin
      tick();
      n1++;
    end
    check("t2_reached_run", 32'(n1 < 20), 32'd1);
    pio_we = 1'b1; pio_addr = 19'd1234;   pio_data = 8'h5A;
    pio_exp_q.push_back({pio_addr, pio_data});
    @(posedge clk); #1;
    pio_we = 1'b1; pio_addr = 19'd300000; pio_data = 8'hC3;
    pio_exp_q.push_back({pio_addr, pio_data});
    tick();
    wait_idle("t2_idle", 50);
    compare_fill("t2", 10, 5, 3, 2, 8'hA5);

    // T3: bottom-right corner clips to 2x1
    clear_queues();
    program_rect(638, 479, 5, 5, 8'h77);
    avm_write(2'd0, 32'h1);
    wait_idle("t3_idle", 50);
    compare_fill("t3", 638, 479, 5, 5, 8'h77);
    check("t3_last_addr", 32'(eng_addr_q.size() == 2 ? int'(eng_addr_q[1]) : -1), 32'd307199);

    // T4: zero width completes with no writes, done two cycles after SETUP
    clear_queues();
    program_rect(0, 0, 0, 4, 8'h11);
    avm_write(2'd0, 32'h1);
    check("t4_setup_ctrl", readdata, 32'h1);
    tick();
    check("t4_done_state_ctrl", readdata, 32'h1);
    tick();
    check("t4_done_set", readdata, 32'h2);
    tick();
    check("t4_no_writes", 32'(eng_addr_q.size()), 32'd0);

    // Random fills with random PIO interference
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) begin
        x0 = 620 + $urandom_range(0, 30);
        y0 = 470 + $urandom_range(0, 15);
      end else begin
        x0 = $urandom_range(0, 700);
        y0 = $urandom_range(0, 500);
      end
      w   = $urandom_range(0, 24);
      h   = $urandom_range(0, 6);
      col = 8'($urandom);
      clear_queues();
      program_rect(x0, y0, w, h, col);
      rand_pio = 1'b1;
      avm_write(2'd0, 32'h1);
      wait_idle($sformatf("rand%0d_idle", k), 600);
      compare_fill($sformatf("rand%0d", k), x0, y0, w, h, col);
      check($sformatf("rand%0d_done", k), readdata, 32'h2);
    end

    // T5: full-screen fill, ignored restart, abort
    clear_queues();
    program_rect(0, 0, 640, 480, 8'h3C);
    avm_write(2'd0, 32'h1);
    n1 = 0;
    while ((eng_addr_q.size() < 100) && (n1 < 400)) begin
      tick();
      n1++;
    end
    check("t5_reached_100", 32'(n1 < 400), 32'd1);
    avm_write(2'd1, {7'd0, 9'd5, 6'd0, 10'd5});
    avm_write(2'd0, 32'h1);
    avm_write(2'd0, 32'h2);
    check("t5_abort_ctrl", readdata, 32'h0);
    repeat (3) tick();
    n1 = eng_addr_q.size();
    repeat (20) tick();
    check("t5_no_more_writes", 32'(eng_addr_q.size()), 32'(n1));
    check("t5_pix_we_low", 32'(pix_we), 32'd0);
    bad_i = -1;
    for (int i = 0; i < eng_addr_q.size(); i++)
      if ((bad_i < 0) && ((int'(eng_addr_q[i]) != i) || (eng_data_q[i] !== 8'h3C))) bad_i = i;
    check("t5_prefix_first_bad_idx", 32'(bad_i), 32'hFFFF_FFFF);
    clear_queues();
    avm_write(2'd2, {6'd0, 10'd1, 5'd0, 11'd2});
    avm_write(2'd0, 32'h1);
    wait_idle("t5_refill_idle", 50);
    compare_fill("t5_refill", 5, 5, 2, 1, 8'h3C);

    // T6: interrupt, write-1-to-clear, async reset mid-RUN
    clear_queues();
    program_rect(100, 100, 4, 3, 8'h99);
    avm_write(2'd0, 32'h5);
    wait_idle("t6_idle", 50);
    check("t6_irq_set", 32'(irq), 32'd1);
    check("t6_ctrl", readdata, 32'h6);
    avm_write(2'd0, 32'hC);
    check("t6_irq_clr", 32'(irq), 32'd0);
    check("t6_ctrl_clr", readdata, 32'h4);
    program_rect(0, 0, 640, 480, 8'h11);
    avm_write(2'd0, 32'h5);
    repeat (10) tick();
    check("t6_running", 32'(pix_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_pix_we", 32'(pix_we), 32'd0);
    check("t6_rst_pix_addr", 32'(pix_addr), 32'd0);
    check("t6_rst_pix_data", 32'(pix_data), 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_ctrl", readdata, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("t6_post_rst_ctrl", readdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
